// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared definitions for the VGA framebuffer fill path: frame
//               geometry, the fill command record, the fill FSM encoding,
//               AXI-lite write response codes and a constant-multiply helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    localparam int CMD_X_W   = 9;
    localparam int CMD_Y_W   = 8;
    localparam int COLOR_W   = 12;

    typedef struct packed {
        logic [CMD_X_W-1:0] x;
        logic [CMD_Y_W-1:0] y;
        logic [CMD_X_W-1:0] w;
        logic [CMD_Y_W-1:0] h;
        logic [COLOR_W-1:0] color;
    } fill_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESP    = 2'd2,
        ST_ADVANCE = 2'd3
    } fill_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Multiply by a constant as a sum of shifted copies; with k fixed at
    // elaboration this reduces to a handful of adders, never a multiplier.
    function automatic logic [31:0] const_mul(input logic [31:0] a, input int k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 31; i++) begin
            if (k[i]) begin
                acc = acc + (a << i);
            end
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_write_issue.sv
`default_nettype none
// ============================================================================
// Module      : axil_write_issue
// Description : Single-transaction AXI-lite write sequencer. A start strobe
//               loads address/data and raises awvalid and wvalid; each valid
//               drops after its own handshake; bready is raised once both
//               have completed and held until the B handshake.
// Ports       : start/addr/data  - launch one write (only while !busy)
//               busy             - a write is in flight
//               done             - strobe on the B handshake
//               resp_err         - qualifies done: bresp was not OKAY
//               aw*/w*/b*        - master side of the write channels
// Revision    : 1.0 - initial release
// ============================================================================
module axil_write_issue #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  resp_err,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    import vga_pkg::*;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;

    // A channel counts as finished if it already handshook or does so now.
    logic w_aw_ok;
    logic w_w_ok;

    assign w_aw_ok = !r_awvalid || awready;
    assign w_w_ok  = !r_wvalid  || wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else if (start) begin
            r_awaddr  <= addr;
            r_wdata   <= data;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
        end else begin
            if (r_awvalid && awready) begin
                r_awvalid <= 1'b0;
            end
            if (r_wvalid && wready) begin
                r_wvalid <= 1'b0;
            end
            if ((r_awvalid || r_wvalid) && w_aw_ok && w_w_ok) begin
                r_bready <= 1'b1;
            end
            if (r_bready && bvalid) begin
                r_bready <= 1'b0;
            end
        end
    end

    assign awaddr   = r_awaddr;
    assign wdata    = r_wdata;
    assign awvalid  = r_awvalid;
    assign wvalid   = r_wvalid;
    assign bready   = r_bready;
    assign busy     = r_awvalid || r_wvalid || r_bready;
    assign done     = r_bready && bvalid;
    assign resp_err = done && (bresp != RESP_OKAY);

endmodule
`default_nettype wire

// File: rtl/vga_fill_master.sv
`default_nettype none
// ============================================================================
// Module      : vga_fill_master
// Description : Rectangle-fill write initiator for the VGA framebuffer. Clips
//               a (x, y, w, h, color) command to the frame and issues one
//               single-beat AXI-lite write per pixel, row-major, with at most
//               one write outstanding.
// Ports       : cmd_*            - fill command, accepted on valid && ready
//               busy / done      - command in progress / completion pulse
//               err              - sticky non-OKAY response since last accept
//               aw*/w*/b*        - master side of the framebuffer write port
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fill_master #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 17,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_WIDTH-1:0]    cmd_x,
    input  logic [Y_WIDTH-1:0]    cmd_y,
    input  logic [X_WIDTH-1:0]    cmd_w,
    input  logic [Y_WIDTH-1:0]    cmd_h,
    input  logic [DATA_WIDTH-1:0] cmd_color,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    import vga_pkg::*;

    localparam logic [X_WIDTH:0]    c_fb_w     = (X_WIDTH+1)'(FB_WIDTH);
    localparam logic [Y_WIDTH:0]    c_fb_h     = (Y_WIDTH+1)'(FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] c_row_step = ADDR_WIDTH'(FB_WIDTH);

    fill_state_t           r_state;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [X_WIDTH-1:0]    r_x0;
    logic [X_WIDTH:0]      r_x_end;
    logic [Y_WIDTH:0]      r_y_end;
    logic [X_WIDTH:0]      r_cur_x;
    logic [Y_WIDTH:0]      r_cur_y;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [DATA_WIDTH-1:0] r_color;

    logic                  w_accept;
    logic                  w_empty;
    logic [X_WIDTH:0]      w_x_sum;
    logic [Y_WIDTH:0]      w_y_sum;
    logic [X_WIDTH:0]      w_x_end_clip;
    logic [Y_WIDTH:0]      w_y_end_clip;
    logic [ADDR_WIDTH-1:0] w_cmd_row_base;
    logic [X_WIDTH:0]      w_x_inc;
    logic                  w_wrap;
    logic [X_WIDTH:0]      w_next_x;
    logic [Y_WIDTH:0]      w_next_y;
    logic [ADDR_WIDTH-1:0] w_next_row_base;
    logic                  w_last;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_start_addr;
    logic [DATA_WIDTH-1:0] w_start_data;
    logic                  w_wr_busy;
    logic                  w_wr_done;
    logic                  w_wr_err;
    logic                  w_aw_ok;
    logic                  w_w_ok;

    // Command-side clipping; sums are one bit wider so they cannot wrap.
    assign w_accept       = cmd_valid && r_cmd_ready && (r_state == ST_IDLE);
    assign w_x_sum        = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign w_y_sum        = {1'b0, cmd_y} + {1'b0, cmd_h};
    assign w_x_end_clip   = (w_x_sum > c_fb_w) ? c_fb_w : w_x_sum;
    assign w_y_end_clip   = (w_y_sum > c_fb_h) ? c_fb_h : w_y_sum;
    assign w_empty        = (cmd_w == '0) || (cmd_h == '0) ||
                            ({1'b0, cmd_x} >= c_fb_w) || ({1'b0, cmd_y} >= c_fb_h);
    assign w_cmd_row_base = ADDR_WIDTH'(const_mul(32'(cmd_y), FB_WIDTH));

    // Raster stepping used in ADVANCE; the same values seed the next write.
    assign w_x_inc         = r_cur_x + 1'b1;
    assign w_wrap          = (w_x_inc == r_x_end);
    assign w_next_x        = w_wrap ? {1'b0, r_x0} : w_x_inc;
    assign w_next_y        = w_wrap ? (r_cur_y + 1'b1) : r_cur_y;
    assign w_next_row_base = w_wrap ? (r_row_base + c_row_step) : r_row_base;
    assign w_last          = w_wrap && (w_next_y == r_y_end);

    // The write is launched on the edge that enters ISSUE, so address and
    // data come from the command (first pixel) or from the stepped raster.
    assign w_start      = !w_wr_busy &&
                          ((w_accept && !w_empty) || (r_state == ST_ADVANCE && !w_last));
    assign w_start_addr = (r_state == ST_IDLE) ? (w_cmd_row_base + ADDR_WIDTH'(cmd_x))
                                               : (w_next_row_base + ADDR_WIDTH'(w_next_x));
    assign w_start_data = (r_state == ST_IDLE) ? cmd_color : r_color;

    assign w_aw_ok = !awvalid || awready;
    assign w_w_ok  = !wvalid  || wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_x0        <= '0;
            r_x_end     <= '0;
            r_y_end     <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_row_base  <= '0;
            r_color     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_err      <= 1'b0;
                        r_x0       <= cmd_x;
                        r_x_end    <= w_x_end_clip;
                        r_y_end    <= w_y_end_clip;
                        r_cur_x    <= {1'b0, cmd_x};
                        r_cur_y    <= {1'b0, cmd_y};
                        r_row_base <= w_cmd_row_base;
                        r_color    <= cmd_color;
                        if (w_empty) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= ST_ISSUE;
                            r_busy      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_aw_ok && w_w_ok) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_wr_done) begin
                        if (w_wr_err) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    r_cur_x    <= w_next_x;
                    r_cur_y    <= w_next_y;
                    r_row_base <= w_next_row_base;
                    if (w_last) begin
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axil_write_issue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .addr     (w_start_addr),
        .data     (w_start_data),
        .busy     (w_wr_busy),
        .resp_err (w_wr_err),
        .done     (w_wr_done),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready)
    );

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign awprot    = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_vga_fill_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fill_master
// Description : Self-checking bench for vga_fill_master. A responsive slave
//               with programmable AW/W/B delays captures each write and pops
//               the expected address/data from a scoreboard queue filled by a
//               clipping reference model when each command is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fill_master;
    import vga_pkg::*;

    localparam int DW = 12;
    localparam int AW = 17;
    localparam int XW = 9;
    localparam int YW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic [XW-1:0] cmd_w;
    logic [YW-1:0] cmd_h;
    logic [DW-1:0] cmd_color;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;

    always #5 clk = ~clk;

    vga_fill_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FB_WIDTH   (320),
        .FB_HEIGHT  (240),
        .X_WIDTH    (XW),
        .Y_WIDTH    (YW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    // Slave configuration and state
    int            aw_dly = 0;
    int            w_dly  = 0;
    int            b_dly  = 0;
    int            err_at = -1;
    int            b_total = 0;
    int            done_cnt = 0;
    bit            aw_got, w_got, aw_hs, w_hs, b_hs;
    int            aw_wait, w_wait, b_wait;
    logic [AW-1:0] cap_addr, l_awaddr;
    logic [DW-1:0] cap_data, l_wdata;
    logic          l_awvalid, l_wvalid, l_bready;
    wr_t           exp_wr;

    initial begin : slave
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        l_awvalid = 1'b0; l_wvalid = 1'b0; l_bready = 1'b0;
        l_awaddr = '0; l_wdata = '0; cap_addr = '0; cap_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
                l_awvalid = 1'b0; l_wvalid = 1'b0; l_bready = 1'b0;
            end else begin
                // Handshakes that completed on the preceding rising edge
                aw_hs = l_awvalid && awready;
                w_hs  = l_wvalid && wready;
                b_hs  = bvalid && l_bready;
                if (aw_hs) begin aw_got = 1; cap_addr = l_awaddr; awready = 1'b0; end
                if (w_hs)  begin w_got = 1;  cap_data = l_wdata;  wready  = 1'b0; end
                if ((aw_hs || w_hs) && aw_got && w_got) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {15'd0, cap_addr}, 32'hFFFF_FFFF);
                    end else begin
                        exp_wr = exp_q.pop_front();
                        check("awaddr", {15'd0, cap_addr}, {15'd0, exp_wr.addr});
                        check("wdata", {20'd0, cap_data}, {20'd0, exp_wr.data});
                    end
                end
                if (b_hs) begin
                    bvalid = 1'b0; bresp = RESP_OKAY;
                    aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
                    b_total++;
                end
                // Valids and payloads must hold while stalled
                if (l_awvalid && !aw_hs) begin
                    check("aw_hold", {31'd0, awvalid}, 32'd1);
                    check("aw_addr_stable", {15'd0, awaddr}, {15'd0, l_awaddr});
                end
                if (l_wvalid && !w_hs) begin
                    check("w_hold", {31'd0, wvalid}, 32'd1);
                    check("w_data_stable", {20'd0, wdata}, {20'd0, l_wdata});
                end
                // One write outstanding; bready only while a response is due
                if (aw_got) check("aw_single", {31'd0, awvalid}, 32'd0);
                if (w_got)  check("w_single", {31'd0, wvalid}, 32'd0);
                if (!(aw_got && w_got)) check("bready_early", {31'd0, bready}, 32'd0);
                // Drive ready/response for the next edge
                if (awvalid && !aw_got) begin aw_wait++; if (aw_wait > aw_dly) awready = 1'b1; end
                if (wvalid && !w_got)   begin w_wait++;  if (w_wait > w_dly)   wready  = 1'b1; end
                if (aw_got && w_got && !bvalid) begin
                    b_wait++;
                    if (b_wait > b_dly) begin
                        bvalid = 1'b1;
                        bresp  = (b_total == err_at) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                l_awvalid = awvalid; l_awaddr = awaddr;
                l_wvalid  = wvalid;  l_wdata  = wdata;
                l_bready  = bready;
            end
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (!rst && done) done_cnt++;
        end
    end

    // Queue the clipped raster of a command and present it.
    task automatic push_and_accept(input int x, input int y, input int w, input int h,
                                   input int color, output int n);
        fill_cmd_t c;
        int xe, ye, cyc;
        xe = (x + w > 320) ? 320 : x + w;
        ye = (y + h > 240) ? 240 : y + h;
        n = 0;
        for (int yy = y; yy < ye; yy++) begin
            for (int xx = x; xx < xe; xx++) begin
                exp_q.push_back('{addr: AW'(yy * 320 + xx), data: DW'(color)});
                n++;
            end
        end
        c.x = XW'(x); c.y = YW'(y); c.w = XW'(w); c.h = YW'(h); c.color = DW'(color);
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_x = c.x; cmd_y = c.y; cmd_w = c.w; cmd_h = c.h; cmd_color = c.color;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("err_cleared", {31'd0, err}, 32'd0);
        if (n > 0) begin
            check("busy", {31'd0, busy}, 32'd1);
            check("cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        end
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input int color, input bit exp_err, input int exp_lat);
        int n, base_done, base_b, lat;
        base_done = done_cnt;
        base_b    = b_total;
        push_and_accept(x, y, w, h, color, n);
        lat = 1;
        while (!done && lat < 5000) begin @(negedge clk); lat++; end
        check("done_seen", {31'd0, done}, 32'd1);
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("err", {31'd0, err}, {31'd0, exp_err});
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", {31'd0, err}, {31'd0, exp_err});
        check("done_once", done_cnt - base_done, 1);
        check("b_count", b_total - base_b, n);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, base_b, base_done, cyc;
        rst = 1'b1; cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        check("rst_awaddr", {15'd0, awaddr}, 32'd0);
        check("rst_wdata", {20'd0, wdata}, 32'd0);
        check("awprot", {29'd0, awprot}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single pixel, zero-wait: ISSUE/RESP/ADVANCE then done in IDLE
        run_cmd(10, 5, 1, 1, 12'hF00, 1'b0, 4);
        // 2x2 fill: 1610,1611,1930,1931
        run_cmd(10, 5, 2, 2, 12'h0A5, 1'b0, 13);
        // Clipped at the bottom-right corner: 76798, 76799
        run_cmd(318, 239, 5, 3, 12'h123, 1'b0, -1);
        // Empty commands: no traffic, done on the next cycle
        run_cmd(320, 10, 4, 4, 12'h456, 1'b0, 1);
        run_cmd(20, 10, 0, 4, 12'h789, 1'b0, 1);
        run_cmd(20, 240, 3, 1, 12'h789, 1'b0, 1);

        // Backpressure on every channel, both orderings of AW vs W
        aw_dly = 3; w_dly = 1; b_dly = 4;
        run_cmd(100, 50, 2, 2, 12'hABC, 1'b0, -1);
        aw_dly = 0; w_dly = 2; b_dly = 1;
        run_cmd(0, 0, 3, 1, 12'h0F0, 1'b0, -1);
        aw_dly = 0; w_dly = 0; b_dly = 0;

        // Slave error on the 2nd of 4 writes; err sticky until next accept
        err_at = b_total + 1;
        run_cmd(200, 100, 2, 2, 12'hE0E, 1'b1, -1);
        err_at = -1;
        run_cmd(7, 7, 1, 1, 12'h001, 1'b0, 4);

        // Reset in the middle of a 2x2 fill
        base_b = b_total;
        base_done = done_cnt;
        push_and_accept(30, 20, 2, 2, 12'h333, n);
        cyc = 0;
        while ((b_total - base_b) < 2 && cyc < 200) begin @(negedge clk); cyc++; end
        check("mid_fill_progress", b_total - base_b, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
        check("mrst_awaddr", {15'd0, awaddr}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mrst_no_done", done_cnt - base_done, 0);
        run_cmd(10, 5, 2, 2, 12'h5A5, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fill_master.md
Name: vga_fill_master

Overview:
- Write initiator for the VGA framebuffer's AXI-lite-style write port; it owns the master side of the AW/W/B channels.
- Accepts a rectangle-fill command (x, y, w, h, colour) and issues one single-beat write per pixel, row-major.
- Sits between the CPU/peripheral command path and the framebuffer RAM. Clips each rectangle to the frame and reports completion and response errors.

Parameters:
DATA_WIDTH, 12, pixel colour width (RGB444)
ADDR_WIDTH, 17, framebuffer word-address width
FB_WIDTH, 320, frame width in pixels
FB_HEIGHT, 240, frame height in pixels
X_WIDTH, 9, width of x / w command fields
Y_WIDTH, 8, width of y / h command fields

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  fill command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_x  in  X_WIDTH  left column
cmd_y  in  Y_WIDTH  top row
cmd_w  in  X_WIDTH  width in pixels
cmd_h  in  Y_WIDTH  height in pixels
cmd_color  in  DATA_WIDTH  fill colour
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
err  out  1  sticky: some bresp != 0 since last accepted command
awaddr  out  ADDR_WIDTH  write address
awprot  out  3  constant 3'b000
awvalid  out  1  address valid
awready  in  1  address accepted
wdata  out  DATA_WIDTH  write data
wvalid  out  1  data valid
wready  in  1  data accepted
bresp  in  2  write response
bvalid  in  1  response valid
bready  out  1  response accepted

Behaviour:
- Reset values: cmd_ready=0, busy=0, done=0, err=0, awvalid=0, wvalid=0, bready=0, awaddr=0, wdata=0. Command state and FSM state return to IDLE.
- Reset mid-command aborts the command immediately. No done pulse is produced.
- FSM states: IDLE, ISSUE, RESP, ADVANCE.
- IDLE:
  - cmd_ready=1.
  - On accept, register the clip results: x0=cmd_x, x_end=min(cmd_x+cmd_w, FB_WIDTH), y_end=min(cmd_y+cmd_h, FB_HEIGHT). Compute these sums at X_WIDTH+1 / Y_WIDTH+1 bits so they cannot overflow.
  - row_base = cmd_y*FB_WIDTH. Compute this with a shift-add constant multiply. No generic multiplier.
  - Clear err.
  - Empty rectangle (w==0, h==0, cmd_x>=FB_WIDTH or cmd_y>=FB_HEIGHT): pulse done in the next cycle, return to IDLE, issue no bus traffic.
  - Otherwise go to ISSUE with cur_x=cmd_x, cur_y=cmd_y.
- ISSUE:
  - Assert awvalid and wvalid together, with awaddr=row_base+cur_x (truncated to ADDR_WIDTH) and wdata=colour.
  - Each valid is held stable until its own ready is seen. The AW and W handshakes may complete in the same cycle or in different cycles, in either order.
  - Per-channel done flags drop the corresponding valid after its handshake.
  - Once both handshakes have completed, go to RESP.
- RESP:
  - bready=1. On bvalid: if bresp!=0, set err. Go to ADVANCE.
  - bready is asserted only in RESP. At most one write is outstanding.
- ADVANCE (one cycle, no bus activity):
  - Increment cur_x.
  - If cur_x+1==x_end: set cur_x=x0, cur_y+=1, row_base+=FB_WIDTH.
  - If the new cur_y==y_end: pulse done, go to IDLE. Otherwise go to ISSUE.
- busy=1 in every state except IDLE.
- cmd_ready=0 while busy. Commands presented while busy are held off, not dropped.
- Throughput with zero-wait slave: 3 cycles per pixel (ISSUE, RESP, ADVANCE).
- awprot is constant 0.
- err stays readable after done until the next accepted command clears it.

Decomposition:
- Shared package vga_pkg holds:
  - constants FB_WIDTH, FB_HEIGHT
  - typedef fill_cmd_t (x, y, w, h, color)
  - enum fill_state_t
  - bresp codes OKAY/SLVERR
- Natural sub-module: axil_write_issue, a single-transaction AW/W/B sequencer. Interface: start, addr, data in; busy, resp_err, done out.

Test Plan:
- Single pixel: cmd (x=10,y=5,w=1,h=1,color=0xF00), zero-wait slave -> one write, awaddr=1610, wdata=0xF00; done pulses once; err=0.
- 2x2 fill at (10,5) -> awaddrs in order 1610,1611,1930,1931; exactly 4 B handshakes, then done.
- Clipping: (x=318,y=239,w=5,h=3) -> writes only 76798, 76799; x=320 or w=0 -> no traffic, done pulse within 2 cycles.
- Backpressure: awready delayed 3 cycles, wready 1 cycle, bvalid 4 cycles -> valids held stable with constant addr/data; no duplicate or lost writes; 1 write outstanding max.
- Error: slave returns bresp=2 on 2nd of 4 writes -> all 4 writes still issued, err=1 after done, cleared on next accepted command.
- Reset asserted mid-fill (after 2 of 4 writes) -> next cycle all outputs at reset values, no done; a subsequent command runs normally.
